// File: rtl/coherence_msg_responder.sv
// L1-side responder for directory coherence messages (INV / FETCH / FETCH_INV).
// Serialises one snoop at a time: stall CPU, look up the line, apply the MSI change, reply.
module coherence_msg_responder #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int MSG_W  = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              msg_valid,
  output logic              msg_ready,
  input  logic [MSG_W-1:0]  msg_code,
  input  logic [ADDR_W-1:0] msg_addr,
  input  logic              cpu_busy,
  output logic              snoop_block,
  output logic [ADDR_W-1:0] lk_addr,
  input  logic              lk_hit,
  input  logic [1:0]        lk_state,
  input  logic [DATA_W-1:0] lk_data,
  output logic              upd_en,
  output logic [ADDR_W-1:0] upd_addr,
  output logic [1:0]        upd_state,
  output logic              reply_valid,
  input  logic              reply_ready,
  output logic [MSG_W-1:0]  reply_code,
  output logic [ADDR_W-1:0] reply_addr,
  output logic [DATA_W-1:0] reply_data,
  output logic [7:0]        wb_count
);

  localparam logic [MSG_W-1:0] MSG_INV       = MSG_W'(3'b001);
  localparam logic [MSG_W-1:0] MSG_FETCH     = MSG_W'(3'b010);
  localparam logic [MSG_W-1:0] MSG_FETCH_INV = MSG_W'(3'b011);
  localparam logic [MSG_W-1:0] RPL_ACK       = MSG_W'(3'b100);
  localparam logic [MSG_W-1:0] RPL_DATA_WB   = MSG_W'(3'b101);
  localparam logic [MSG_W-1:0] RPL_NACK      = MSG_W'(3'b110);

  localparam logic [1:0] ST_I = 2'b00;
  localparam logic [1:0] ST_S = 2'b01;
  localparam logic [1:0] ST_M = 2'b10;

  typedef enum logic [2:0] {IDLE, WAIT, LOOKUP, UPDATE, REPLY} state_t;

  typedef struct packed {
    logic             upd;
    logic [1:0]       newState;
    logic [MSG_W-1:0] code;
    logic             wb;
  } action_t;

  state_t            state;
  logic [MSG_W-1:0]  reqCode;
  logic [ADDR_W-1:0] reqAddr;
  logic [MSG_W-1:0]  pendCode;
  logic [DATA_W-1:0] pendData;
  action_t           actNow;

  // MSI action table; lk_state 11 falls through as invalid.
  function automatic action_t decide(input logic [MSG_W-1:0] code,
                                     input logic hit, input logic [1:0] st);
    action_t a;
    logic isM;
    logic isS;
    isM = hit && (st == ST_M);
    isS = hit && (st == ST_S);
    a.upd      = 1'b0;
    a.newState = ST_I;
    a.code     = RPL_NACK;
    a.wb       = 1'b0;
    case (code)
      MSG_INV: begin
        a.upd  = isM || isS;
        a.code = isM ? RPL_DATA_WB : RPL_ACK;
        a.wb   = isM;
      end
      MSG_FETCH: begin
        a.upd      = isM;
        a.newState = ST_S;
        a.code     = isM ? RPL_DATA_WB : (isS ? RPL_ACK : RPL_NACK);
        a.wb       = isM;
      end
      MSG_FETCH_INV: begin
        a.upd  = isM || isS;
        a.code = isM ? RPL_DATA_WB : (isS ? RPL_ACK : RPL_NACK);
        a.wb   = isM;
      end
      default: a.code = RPL_NACK;
    endcase
    return a;
  endfunction

  function automatic logic [7:0] satInc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  always_comb begin
    actNow = decide(reqCode, lk_hit, lk_state);
  end

  // Request and lookup payload: data only, never reset.
  always_ff @(posedge clk) begin
    if (state == IDLE && msg_valid && msg_ready) begin
      reqCode <= msg_code;
      reqAddr <= msg_addr;
    end
    if (state == LOOKUP) begin
      pendCode <= actNow.code;
      pendData <= actNow.wb ? lk_data : '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      msg_ready   <= 1'b0;
      snoop_block <= 1'b0;
      lk_addr     <= '0;
      upd_en      <= 1'b0;
      upd_addr    <= '0;
      upd_state   <= '0;
      reply_valid <= 1'b0;
      reply_code  <= '0;
      reply_addr  <= '0;
      reply_data  <= '0;
      wb_count    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (msg_valid && msg_ready) begin
            msg_ready   <= 1'b0;
            snoop_block <= 1'b1;
            state       <= WAIT;
          end else begin
            msg_ready <= 1'b1;
          end
        end
        WAIT: begin
          if (!cpu_busy) begin
            lk_addr <= reqAddr;
            state   <= LOOKUP;
          end
        end
        // Decision is taken from the live lookup response so upd_en lands in UPDATE.
        LOOKUP: begin
          lk_addr   <= '0;
          upd_en    <= actNow.upd;
          upd_addr  <= actNow.upd ? reqAddr : '0;
          upd_state <= actNow.upd ? actNow.newState : ST_I;
          state     <= UPDATE;
        end
        UPDATE: begin
          upd_en      <= 1'b0;
          upd_addr    <= '0;
          upd_state   <= '0;
          reply_valid <= 1'b1;
          reply_code  <= pendCode;
          reply_addr  <= reqAddr;
          reply_data  <= pendData;
          state       <= REPLY;
        end
        REPLY: begin
          if (reply_ready) begin
            reply_valid <= 1'b0;
            reply_code  <= '0;
            reply_addr  <= '0;
            reply_data  <= '0;
            snoop_block <= 1'b0;
            msg_ready   <= 1'b1;
            state       <= IDLE;
            if (reply_code == RPL_DATA_WB) wb_count <= satInc(wb_count);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_msg_responder.sv
// Bench for coherence_msg_responder: emulates the L1 arrays and the directory,
// checks replies, state updates, timing and wb_count against a rule-table model.
module tb_coherence_msg_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       msg_valid;
  logic       msg_ready;
  logic [2:0] msg_code;
  logic [7:0] msg_addr;
  logic       cpu_busy;
  logic       snoop_block;
  logic [7:0] lk_addr;
  logic       lk_hit;
  logic [1:0] lk_state;
  logic [7:0] lk_data;
  logic       upd_en;
  logic [7:0] upd_addr;
  logic [1:0] upd_state;
  logic       reply_valid;
  logic       reply_ready;
  logic [2:0] reply_code;
  logic [7:0] reply_addr;
  logic [7:0] reply_data;
  logic [7:0] wb_count;

  logic       hitArr  [256];
  logic [1:0] stArr   [256];
  logic [7:0] dataArr [256];

  localparam logic [2:0] ACK = 3'b100;
  localparam logic [2:0] WB  = 3'b101;
  localparam logic [2:0] NAK = 3'b110;

  int passCnt = 0;
  int totalCnt = 0;
  int expWb = 0;

  typedef struct {
    bit         timeout;
    bit         done;
    int         updCnt;
    int         updRel;
    logic [7:0] updAddr;
    logic [1:0] updState;
    int         repRel;
    int         lkRel;
    logic [2:0] repCode;
    logic [7:0] repAddr;
    logic [7:0] repData;
    bit         unstable;
    bit         readyLeak;
    bit         blockDrop;
  } obs_t;

  assign lk_hit   = hitArr[lk_addr];
  assign lk_state = stArr[lk_addr];
  assign lk_data  = dataArr[lk_addr];

  always #5 clk = ~clk;

  coherence_msg_responder dut (
    .clk(clk), .rst(rst),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_code(msg_code), .msg_addr(msg_addr),
    .cpu_busy(cpu_busy), .snoop_block(snoop_block),
    .lk_addr(lk_addr), .lk_hit(lk_hit), .lk_state(lk_state), .lk_data(lk_data),
    .upd_en(upd_en), .upd_addr(upd_addr), .upd_state(upd_state),
    .reply_valid(reply_valid), .reply_ready(reply_ready), .reply_code(reply_code),
    .reply_addr(reply_addr), .reply_data(reply_data), .wb_count(wb_count)
  );

  // Reference rules: classify the line as M / S / miss, then read off the action.
  function automatic void model(input logic [2:0] c, input logic h, input logic [1:0] s,
                                output bit doUpd, output logic [1:0] ns, output logic [2:0] rc);
    int cls;
    cls = (!h) ? 0 : (s == 2'b10) ? 2 : (s == 2'b01) ? 1 : 0;
    doUpd = 0; ns = 2'b00; rc = NAK;
    if (c == 3'd1) begin
      rc = (cls == 2) ? WB : ACK; doUpd = (cls != 0);
    end else if (c == 3'd2) begin
      rc = (cls == 2) ? WB : (cls == 1) ? ACK : NAK; doUpd = (cls == 2); ns = 2'b01;
    end else if (c == 3'd3) begin
      rc = (cls == 2) ? WB : (cls == 1) ? ACK : NAK; doUpd = (cls != 0);
    end
  endfunction

  task automatic run_msg(input logic [2:0] c, input logic [7:0] a, input int busy,
                         input int dly, input bit holdValid, output obs_t o);
    int n;
    int waited;
    bit hsPending;
    o.timeout = 0; o.done = 0; o.updCnt = 0; o.updRel = -1; o.updAddr = '0; o.updState = '0;
    o.repRel = -1; o.lkRel = -1; o.repCode = '0; o.repAddr = '0; o.repData = '0;
    o.unstable = 0; o.readyLeak = 0; o.blockDrop = 0;
    n = 0; waited = 0; hsPending = 0;
    while (msg_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if (msg_ready !== 1'b1) begin o.timeout = 1; return; end
    msg_valid = 1; msg_code = c; msg_addr = a; cpu_busy = (busy > 0);
    @(negedge clk);
    if (!holdValid) msg_valid = 0;
    for (int rel = 0; rel < 60; rel++) begin
      if (hsPending) begin o.done = 1; break; end
      cpu_busy = (rel < busy);
      if (msg_ready !== 1'b0) o.readyLeak = 1;
      if (snoop_block !== 1'b1) o.blockDrop = 1;
      if (lk_addr === a && o.lkRel < 0) o.lkRel = rel;
      if (upd_en === 1'b1) begin
        o.updCnt++; o.updRel = rel; o.updAddr = upd_addr; o.updState = upd_state;
        stArr[upd_addr] = upd_state;
      end
      if (reply_valid === 1'b1) begin
        if (o.repRel < 0) begin
          o.repRel = rel; o.repCode = reply_code; o.repAddr = reply_addr; o.repData = reply_data;
        end else if ({reply_code, reply_addr, reply_data} !== {o.repCode, o.repAddr, o.repData}) begin
          o.unstable = 1;
        end
        if (waited >= dly) begin reply_ready = 1; hsPending = 1; end
        else waited++;
      end else if (o.repRel >= 0) begin
        o.unstable = 1;
      end
      @(negedge clk);
    end
    reply_ready = 0; cpu_busy = 0;
    if (!o.done) o.timeout = 1;
  endtask

  task automatic test_reset();
    rst = 1;
    repeat (3) @(negedge clk);
    totalCnt++;
    if ((|{msg_ready, snoop_block, lk_addr, upd_en, upd_addr, upd_state, reply_valid,
           reply_code, reply_addr, reply_data, wb_count}) !== 1'b0)
      $display("FAIL reset_outputs: some output nonzero during reset, required all 0");
    else passCnt++;
    rst = 0;
    totalCnt++;
    if (msg_ready !== 1'b0) $display("FAIL reset_ready_pre got=%b exp=0", msg_ready); else passCnt++;
    @(negedge clk);
    totalCnt++;
    if (msg_ready !== 1'b1) $display("FAIL reset_ready_post got=%b exp=1", msg_ready); else passCnt++;
  endtask

  task automatic test_inv_hit_m();
    obs_t o;
    hitArr[8'h2A] = 1; stArr[8'h2A] = 2'b10; dataArr[8'h2A] = 8'h5C;
    run_msg(3'd1, 8'h2A, 0, 0, 0, o);
    expWb++;
    totalCnt++; if (o.timeout) $display("FAIL inv_timeout got=1 exp=0"); else passCnt++;
    totalCnt++; if (o.updCnt !== 1 || o.updRel !== 2) $display("FAIL inv_upd_timing cnt=%0d rel=%0d exp cnt=1 rel=2", o.updCnt, o.updRel); else passCnt++;
    totalCnt++; if ({o.updAddr, o.updState} !== {8'h2A, 2'b00}) $display("FAIL inv_upd got=%h/%b exp=2a/00", o.updAddr, o.updState); else passCnt++;
    totalCnt++; if (o.repRel !== 3) $display("FAIL inv_reply_latency got=%0d exp=3", o.repRel); else passCnt++;
    totalCnt++; if ({o.repCode, o.repAddr, o.repData} !== {WB, 8'h2A, 8'h5C}) $display("FAIL inv_reply got=%b/%h/%h exp=101/2a/5c", o.repCode, o.repAddr, o.repData); else passCnt++;
    totalCnt++; if (wb_count !== 8'd1) $display("FAIL inv_wb_count got=%0d exp=1", wb_count); else passCnt++;
    totalCnt++; if (msg_ready !== 1'b1 || snoop_block !== 1'b0 || o.blockDrop) $display("FAIL inv_post_hs ready=%b block=%b drop=%b exp 1/0/0", msg_ready, snoop_block, o.blockDrop); else passCnt++;
  endtask

  task automatic test_fetch();
    obs_t o;
    hitArr[8'h10] = 1; stArr[8'h10] = 2'b01; dataArr[8'h10] = 8'h77;
    run_msg(3'd2, 8'h10, 0, 0, 0, o);
    totalCnt++; if (o.updCnt !== 0) $display("FAIL fetch_s_upd got=%0d exp=0", o.updCnt); else passCnt++;
    totalCnt++; if ({o.repCode, o.repAddr, o.repData} !== {ACK, 8'h10, 8'h00}) $display("FAIL fetch_s_reply got=%b/%h/%h exp=100/10/00", o.repCode, o.repAddr, o.repData); else passCnt++;
    hitArr[8'h11] = 0; stArr[8'h11] = 2'b10; dataArr[8'h11] = 8'h99;
    run_msg(3'd2, 8'h11, 0, 0, 0, o);
    totalCnt++; if ({o.repCode, o.repAddr, o.repData} !== {NAK, 8'h11, 8'h00} || o.updCnt !== 0) $display("FAIL fetch_miss_reply got=%b/%h/%h upd=%0d exp=110/11/00 upd=0", o.repCode, o.repAddr, o.repData, o.updCnt); else passCnt++;
  endtask

  task automatic test_busy();
    obs_t o;
    hitArr[8'h33] = 1; stArr[8'h33] = 2'b10; dataArr[8'h33] = 8'hA5;
    run_msg(3'd3, 8'h33, 4, 0, 0, o);
    expWb++;
    totalCnt++; if (o.blockDrop) $display("FAIL busy_block got=dropped exp=held"); else passCnt++;
    totalCnt++; if (o.lkRel !== 5) $display("FAIL busy_lookup_rel got=%0d exp=5", o.lkRel); else passCnt++;
    totalCnt++; if (o.updCnt !== 1 || o.updRel !== 6 || o.updState !== 2'b00) $display("FAIL busy_upd cnt=%0d rel=%0d st=%b exp 1/6/00", o.updCnt, o.updRel, o.updState); else passCnt++;
    totalCnt++; if ({o.repCode, o.repData} !== {WB, 8'hA5} || o.repRel !== 7) $display("FAIL busy_reply got=%b/%h rel=%0d exp=101/a5 rel=7", o.repCode, o.repData, o.repRel); else passCnt++;
  endtask

  task automatic test_back_to_back();
    obs_t o;
    hitArr[8'h55] = 1; stArr[8'h55] = 2'b01; dataArr[8'h55] = 8'h3C;
    run_msg(3'd1, 8'h55, 0, 5, 1, o);
    totalCnt++; if (o.unstable || o.timeout) $display("FAIL bp_stable unstable=%b timeout=%b exp 0/0", o.unstable, o.timeout); else passCnt++;
    totalCnt++; if (o.readyLeak) $display("FAIL bp_ready_leak got=1 exp=0"); else passCnt++;
    totalCnt++; if ({o.repCode, o.repData} !== {ACK, 8'h00}) $display("FAIL bp_reply got=%b/%h exp=100/00", o.repCode, o.repData); else passCnt++;
    totalCnt++; if (msg_ready !== 1'b1 || snoop_block !== 1'b0) $display("FAIL bp_second_pending ready=%b block=%b exp 1/0", msg_ready, snoop_block); else passCnt++;
    run_msg(3'd2, 8'h55, 0, 0, 0, o);
    totalCnt++; if (o.repCode !== NAK || o.repRel !== 3) $display("FAIL bp_second_reply got=%b rel=%0d exp=110 rel=3", o.repCode, o.repRel); else passCnt++;
  endtask

  task automatic test_random();
    obs_t o;
    logic [7:0] a;
    logic [2:0] c;
    int busy;
    int dly;
    bit doUpd;
    logic [1:0] ns;
    logic [2:0] rc;
    logic [7:0] ed;
    for (int i = 0; i < 40; i++) begin
      a = 8'($urandom_range(0, 255));
      c = 3'($urandom_range(0, 7));
      hitArr[a] = 1'($urandom_range(0, 1));
      stArr[a] = 2'($urandom_range(0, 3));
      dataArr[a] = 8'($urandom_range(0, 255));
      busy = int'($urandom_range(0, 3));
      dly = int'($urandom_range(0, 3));
      model(c, hitArr[a], stArr[a], doUpd, ns, rc);
      ed = (rc == WB) ? dataArr[a] : 8'h00;
      run_msg(c, a, busy, dly, 0, o);
      if (rc == WB && expWb < 255) expWb++;
      totalCnt++;
      if (o.timeout || {o.repCode, o.repAddr, o.repData} !== {rc, a, ed})
        $display("FAIL rand_reply[%0d] code=%0d got=%b/%h/%h exp=%b/%h/%h", i, c, o.repCode, o.repAddr, o.repData, rc, a, ed);
      else passCnt++;
      totalCnt++;
      if (o.repRel !== busy + 3 || o.unstable) $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, o.repRel, busy + 3); else passCnt++;
      totalCnt++;
      if (o.updCnt !== (doUpd ? 1 : 0)) $display("FAIL rand_upd_cnt[%0d] got=%0d exp=%0d", i, o.updCnt, doUpd ? 1 : 0); else passCnt++;
      if (doUpd) begin
        totalCnt++;
        if (o.updRel !== busy + 2 || {o.updAddr, o.updState} !== {a, ns})
          $display("FAIL rand_upd[%0d] rel=%0d %h/%b exp rel=%0d %h/%b", i, o.updRel, o.updAddr, o.updState, busy + 2, a, ns);
        else passCnt++;
      end
    end
    totalCnt++;
    if (wb_count !== 8'(expWb)) $display("FAIL rand_wb_count got=%0d exp=%0d", wb_count, expWb); else passCnt++;
  endtask

  task automatic test_reset_mid();
    bit seen;
    int n;
    hitArr[8'h66] = 1; stArr[8'h66] = 2'b10; dataArr[8'h66] = 8'hC3;
    n = 0;
    while (msg_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    msg_valid = 1; msg_code = 3'd1; msg_addr = 8'h66; cpu_busy = 1;
    @(negedge clk);
    msg_valid = 0;
    totalCnt++; if (snoop_block !== 1'b1) $display("FAIL rstmid_in_wait block=%b exp=1", snoop_block); else passCnt++;
    rst = 1;
    #1;
    totalCnt++;
    if ((|{msg_ready, snoop_block, lk_addr, upd_en, upd_addr, upd_state, reply_valid,
           reply_code, reply_addr, reply_data, wb_count}) !== 1'b0)
      $display("FAIL rstmid_outputs: some output nonzero after async reset, required all 0");
    else passCnt++;
    seen = 0;
    repeat (2) begin @(negedge clk); if (upd_en !== 1'b0 || reply_valid !== 1'b0) seen = 1; end
    rst = 0; cpu_busy = 0;
    repeat (4) begin @(negedge clk); if (upd_en !== 1'b0 || reply_valid !== 1'b0 || snoop_block !== 1'b0) seen = 1; end
    totalCnt++; if (seen) $display("FAIL rstmid_aborted got=activity exp=none"); else passCnt++;
    totalCnt++; if (msg_ready !== 1'b1) $display("FAIL rstmid_idle ready=%b exp=1", msg_ready); else passCnt++;
    expWb = 0;
  endtask

  task automatic test_saturation();
    obs_t o;
    int bad;
    logic [7:0] wbAt255;
    bad = 0; wbAt255 = '0;
    for (int i = 0; i < 256; i++) begin
      hitArr[8'h40] = 1; stArr[8'h40] = 2'b10; dataArr[8'h40] = 8'(i);
      run_msg(3'd1, 8'h40, 0, 0, 0, o);
      if (o.timeout || o.repCode !== WB || o.repData !== 8'(i)) bad++;
      if (i == 254) wbAt255 = wb_count;
    end
    totalCnt++; if (bad != 0) $display("FAIL sat_replies bad=%0d exp=0", bad); else passCnt++;
    totalCnt++; if (wbAt255 !== 8'd255) $display("FAIL sat_at_255 got=%0d exp=255", wbAt255); else passCnt++;
    totalCnt++; if (wb_count !== 8'd255) $display("FAIL sat_hold got=%0d exp=255", wb_count); else passCnt++;
  endtask

  initial begin
    rst = 1; msg_valid = 0; msg_code = '0; msg_addr = '0; cpu_busy = 0; reply_ready = 0;
    for (int i = 0; i < 256; i++) begin hitArr[i] = 0; stArr[i] = 2'b00; dataArr[i] = 8'h00; end
    test_reset();
    test_inv_hit_m();
    test_fetch();
    test_busy();
    test_back_to_back();
    test_random();
    test_reset_mid();
    test_saturation();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
